// File: rtl/inst_fetch.sv
// inst_fetch: fetch sequencer that reads one word from program memory (rd/rdy handshake)
// and hands it to the instruction buffer with a one-cycle ld strobe. Optional WAIT timeout: FETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] inst_out,
    output logic              ld,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    // state  | meaning
    // S_IDLE | waiting for jmp / fetch_en
    // S_WAIT | mem_rd held, waiting for mem_rdy
    // S_LOAD | ld strobe high, inst_out valid
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic [DATA_W-1:0] inst_q;
    logic              ld_q;
    logic              busy_q;
    logic              err_q;
    logic              timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts completed rdy-less WAIT cycles; the edge that would make it TIMEOUT_CYC aborts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            cnt_q <= '0;
        end else if (!mem_rdy) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            inst_q     <= '0;
            ld_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (jmp) begin
                        pc_q <= jmp_addr;
                    end else if (fetch_en) begin
                        mem_addr_q <= pc_q;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rdy) begin
                        inst_q   <= mem_data;
                        pc_q     <= pc_q + ADDR_W'(1);
                        mem_rd_q <= 1'b0;
                        ld_q     <= 1'b1;
                        state_q  <= S_LOAD;
                    end else if (timeout) begin
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign inst_out  = inst_q;
    assign ld        = ld_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign fetch_err = err_q;

endmodule
